// File: rtl/idm_pkg.sv
// Shared types and default widths for the IDM responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package idm_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_t;

endpackage

// File: rtl/idm_responder_if.sv
// Request/response bundle between the core (master) and the IDM responder (slave).
// Latency: n/a (wiring only).
// Backpressure: the master waits for Ready; requests made while Busy are dropped.
interface idm_responder_if #(
   parameter int DATA_W = idm_pkg::DATA_W,
   parameter int ADDR_W = idm_pkg::ADDR_W
);
   logic              Req;
   logic              IDMWrite;
   logic [ADDR_W-1:0] Addr;
   logic [DATA_W-1:0] WD;
   logic              ParInj;
   logic [DATA_W-1:0] RD;
   logic              Ready;
   logic              Busy;
   logic              AddrErr;
   logic              ParErr;

   modport master (
      output Req, IDMWrite, Addr, WD, ParInj,
      input  RD, Ready, Busy, AddrErr, ParErr
   );

   modport slave (
      input  Req, IDMWrite, Addr, WD, ParInj,
      output RD, Ready, Busy, AddrErr, ParErr
   );
endinterface

// File: rtl/idm_array.sv
// Single-port synchronous word array with a registered read port; IDM_PARITY_EN adds a parity bit per word.
// Latency: write and read both take effect on the edge where we/re is high.
// Backpressure: none; out-of-range reads return zero.
module idm_array #(
   parameter int DATA_W = idm_pkg::DATA_W,
   parameter int ADDR_W = idm_pkg::ADDR_W,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef IDM_PARITY_EN
   input  logic              wpar,
   output logic              rpar,
`endif
   output logic [DATA_W-1:0] rdata
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IDM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] wword;
   logic [WORD_W-1:0] rdata_d, rdata_q;
   logic [IDX_W-1:0]  idx;
   logic              in_range;

   assign idx      = addr[IDX_W-1:0];
   assign in_range = 32'(addr) < DEPTH;

`ifdef IDM_PARITY_EN
   assign wword = {wpar, wdata};
   assign rpar  = rdata_q[DATA_W];
`else
   assign wword = wdata;
`endif

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = in_range ? mem[idx] : '0;
   end

   // Storage is deliberately not reset; only the output register is.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wword;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q[DATA_W-1:0];

endmodule

// File: rtl/idm_responder.sv
// IDM memory responder: services one request after WAIT_CYC wait states; IDM_PARITY_EN enables parity check.
// Latency: Req sampled in IDLE gives a Ready pulse WAIT_CYC+1 edges later; one transaction per WAIT_CYC+2 cycles.
// Backpressure: Busy high while outstanding; requests seen outside IDLE are ignored, nothing is queued.
module idm_responder #(
   parameter int DATA_W   = idm_pkg::DATA_W,
   parameter int ADDR_W   = idm_pkg::ADDR_W,
   parameter int DEPTH    = 256,
   parameter int WAIT_CYC = 2
) (
   input  logic          CLK,
   input  logic          RST,
   idm_responder_if.slave bus
);
   import idm_pkg::*;

   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic              wr_q, wr_d;
   logic              inj_q, inj_d;
   logic              commit;
   logic              idle;
   logic              done;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wd;
   logic              c_wr;
   logic              c_inj;
   logic              c_in_range;
   logic              oob_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      wr_d    = wr_q;
      inj_d   = inj_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Req) begin
               addr_d = bus.Addr;
               wd_d   = bus.WD;
               wr_d   = bus.IDMWrite;
               inj_d  = bus.ParInj;
               cnt_d  = WAIT_LD;
               if (WAIT_CYC == 0) begin
                  state_d = DONE;
                  commit  = 1'b1;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               commit  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wd_q    <= '0;
         wr_q    <= 1'b0;
         inj_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         wr_q    <= wr_d;
         inj_q   <= inj_d;
      end
   end

   // Zero-wait commits on the accept edge, so the array sees the live bus then.
   assign idle       = (state_q == IDLE);
   assign done       = (state_q == DONE);
   assign c_addr     = idle ? bus.Addr     : addr_q;
   assign c_wd       = idle ? bus.WD       : wd_q;
   assign c_wr       = idle ? bus.IDMWrite : wr_q;
   assign c_inj      = idle ? bus.ParInj   : inj_q;
   assign c_in_range = 32'(c_addr) < DEPTH;
   assign oob_q      = 32'(addr_q) >= DEPTH;

`ifdef IDM_PARITY_EN
   logic rpar;

   idm_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
      .clk   (CLK),
      .rst_n (RST),
      .we    (commit & c_wr & c_in_range & RST),
      .re    (commit & ~c_wr & RST),
      .addr  (c_addr),
      .wdata (c_wd),
      .wpar  ((^c_wd) ^ c_inj),
      .rpar  (rpar),
      .rdata (bus.RD)
   );

   assign bus.ParErr = done & ~wr_q & ~oob_q & ((^bus.RD) ^ rpar);
`else
   logic unused_par_inj;
   assign unused_par_inj = c_inj;

   idm_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
      .clk   (CLK),
      .rst_n (RST),
      .we    (commit & c_wr & c_in_range & RST),
      .re    (commit & ~c_wr & RST),
      .addr  (c_addr),
      .wdata (c_wd),
      .rdata (bus.RD)
   );

   assign bus.ParErr = 1'b0;
`endif

   assign bus.Ready   = done;
   assign bus.Busy    = ~idle;
   assign bus.AddrErr = done & oob_q;

endmodule

// File: tb/tb_idm_responder.sv
// Randomised self-checking bench for idm_responder: two instances (DEPTH=128/WAIT_CYC=2 and DEPTH=256/WAIT_CYC=0)
// checked against a word-array model; parity checks are active when IDM_PARITY_EN is defined.
module tb_idm_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a, req_b;
   logic        wr, inj;
   logic [7:0]  addr;
   logic [15:0] wd;
   int          sel;

   int n_chk  = 0;
   int n_fail = 0;

   idm_responder_if #(.DATA_W(16), .ADDR_W(8)) if_a ();
   idm_responder_if #(.DATA_W(16), .ADDR_W(8)) if_b ();

   assign if_a.Req = req_a;  assign if_a.IDMWrite = wr;  assign if_a.Addr = addr;
   assign if_a.WD  = wd;     assign if_a.ParInj   = inj;
   assign if_b.Req = req_b;  assign if_b.IDMWrite = wr;  assign if_b.Addr = addr;
   assign if_b.WD  = wd;     assign if_b.ParInj   = inj;

   idm_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYC(2)) u_dut_a (
      .CLK (clk), .RST (rst), .bus (if_a)
   );
   idm_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(0)) u_dut_b (
      .CLK (clk), .RST (rst), .bus (if_b)
   );

   always #5 clk = ~clk;

   logic [15:0] rd_s;
   logic        rdy_s, busy_s, aerr_s, perr_s;
   assign rd_s   = (sel != 0) ? if_b.RD      : if_a.RD;
   assign rdy_s  = (sel != 0) ? if_b.Ready   : if_a.Ready;
   assign busy_s = (sel != 0) ? if_b.Busy    : if_a.Busy;
   assign aerr_s = (sel != 0) ? if_b.AddrErr : if_a.AddrErr;
   assign perr_s = (sel != 0) ? if_b.ParErr  : if_a.ParErr;

   // Reference model: one word array per instance plus the last completed read value.
   int          wait_m  [2] = '{2, 0};
   int          depth_m [2] = '{128, 256};
   logic [15:0] mem_m   [2][256];
   bit          known_m [2][256];
   bit          pbad_m  [2][256];
   logic [15:0] rd_m    [2];
   bit          rdk_m   [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic txn(input int s, input bit w, input logic [7:0] a, input logic [15:0] d, input bit pi);
      int  n;
      bit  seen;
      bit  oob;
      bit  exp_perr;
      sel = s; wr = w; addr = a; wd = d; inj = pi;
      if (s != 0) req_b = 1'b1; else req_a = 1'b1;
      @(posedge clk); #1;
      req_a = 1'b0; req_b = 1'b0;
      n = 1;
      seen = rdy_s;
      while (!seen && n < 20) begin
         check("busy_access", busy_s, 1);
         @(posedge clk); #1;
         n++;
         seen = rdy_s;
      end
      check("ready_seen", seen, 1);
      check("latency", n, wait_m[s] + 1);
      check("busy_done", busy_s, 1);
      oob = (int'(a) >= depth_m[s]);
      check("addr_err", aerr_s, oob);
      exp_perr = 1'b0;
      if (w) begin
         if (!oob) begin
            mem_m[s][a]   = d;
            known_m[s][a] = 1'b1;
            pbad_m[s][a]  = pi;
         end
      end else if (oob) begin
         rd_m[s]  = 16'h0;
         rdk_m[s] = 1'b1;
      end else if (known_m[s][a]) begin
         rd_m[s]  = mem_m[s][a];
         rdk_m[s] = 1'b1;
`ifdef IDM_PARITY_EN
         exp_perr = pbad_m[s][a];
`endif
      end else begin
         rdk_m[s] = 1'b0;
      end
      if (rdk_m[s]) begin
         check("rd_data", rd_s, rd_m[s]);
         check("par_err", perr_s, exp_perr);
      end
      @(posedge clk); #1;
      check("back_idle", {busy_s, rdy_s}, 0);
   endtask

   initial begin
      int nrdy;
      int s;
      bit w;
      logic [7:0] a;
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int nrdy;
      int s;
      bit w;
      logic [7:0] a;
      rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
      wr = 1'b0; inj = 1'b0; addr = '0; wd = '0; sel = 0;
      for (int k = 0; k < 2; k++) begin
         rd_m[k] = 16'h0; rdk_m[k] = 1'b1;
         for (int i = 0; i < 256; i++) begin
            known_m[k][i] = 1'b0; pbad_m[k][i] = 1'b0; mem_m[k][i] = 16'h0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_a", {if_a.RD, if_a.Ready, if_a.Busy, if_a.AddrErr, if_a.ParErr}, 0);
      check("rst_b", {if_b.RD, if_b.Ready, if_b.Busy, if_b.AddrErr, if_b.ParErr}, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic write then read with two wait states.
      txn(0, 1'b1, 8'h10, 16'hBEEF, 1'b0);
      txn(0, 1'b0, 8'h10, 16'h0, 1'b0);
      txn(0, 1'b1, 8'h20, 16'h0A0A, 1'b0);

      // Zero-wait instance.
      txn(1, 1'b1, 8'h10, 16'hCAFE, 1'b0);
      txn(1, 1'b0, 8'h10, 16'h0, 1'b0);

      // Req held high on the zero-wait instance: Ready every other cycle.
      sel = 1; wr = 1'b0; addr = 8'h10; req_b = 1'b1;
      nrdy = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("hold_ready_pattern", rdy_s, (i % 2 == 0));
         if (rdy_s) begin
            nrdy++;
            check("hold_rd", rd_s, 16'hCAFE);
         end
      end
      req_b = 1'b0;
      check("hold_ready_count", nrdy, 4);
      @(posedge clk); #1;
      check("hold_idle", {busy_s, rdy_s}, 0);

      // A request pulsed during ACCESS is ignored.
      sel = 0; wr = 1'b0; addr = 8'h10; req_a = 1'b1;
      @(posedge clk); #1;
      req_a = 1'b0;
      addr = 8'h20; wr = 1'b1; wd = 16'hFFFF; req_a = 1'b1;
      @(posedge clk); #1;
      req_a = 1'b0; wr = 1'b0;
      nrdy = 0;
      for (int i = 0; i < 6; i++) begin
         if (rdy_s) begin
            nrdy++;
            check("busy_req_rd", rd_s, 16'hBEEF);
         end
         @(posedge clk); #1;
      end
      check("busy_req_ready_count", nrdy, 1);
      rd_m[0] = 16'hBEEF; rdk_m[0] = 1'b1;
      txn(0, 1'b0, 8'h20, 16'h0, 1'b0);

      // Out-of-range on the DEPTH=128 instance.
      txn(0, 1'b1, 8'h90, 16'hDEAD, 1'b0);
      txn(0, 1'b0, 8'h90, 16'h0, 1'b0);
      txn(0, 1'b0, 8'h10, 16'h0, 1'b0);

      // Reset in the first ACCESS cycle drops the write.
      txn(0, 1'b1, 8'h05, 16'h5555, 1'b0);
      sel = 0; wr = 1'b1; addr = 8'h05; wd = 16'h1234; req_a = 1'b1;
      @(posedge clk); #1;
      req_a = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_outs", {if_a.RD, if_a.Ready, if_a.Busy, if_a.AddrErr, if_a.ParErr}, 0);
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         rd_m[k] = 16'h0; rdk_m[k] = 1'b1;
      end
      nrdy = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (if_a.Ready) nrdy++;
      end
      check("midrst_no_ready", nrdy, 0);
      txn(0, 1'b0, 8'h05, 16'h0, 1'b0);

`ifdef IDM_PARITY_EN
      txn(0, 1'b1, 8'h30, 16'h00FF, 1'b1);
      txn(0, 1'b0, 8'h30, 16'h0, 1'b0);
      txn(0, 1'b1, 8'h30, 16'h00FF, 1'b0);
      txn(0, 1'b0, 8'h30, 16'h0, 1'b0);
`endif

      // Random mix on both instances.
      for (int i = 0; i < 120; i++) begin
         s = int'($urandom_range(1, 0));
         w = 1'($urandom_range(1, 0));
         a = 8'($urandom_range(15, 0));
         if ($urandom_range(3, 0) == 0) a = a | 8'h80;
         txn(s, w, a, 16'($urandom), 1'($urandom_range(1, 0)));
         if ($urandom_range(3, 0) == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
